// File: rtl/spatz_cluster_pkg.sv
// Shared cluster types: demux target select and default reqrsp bundles.
// The default bundles carry a 32-bit address and a 4-bit core_id.
package spatz_cluster_pkg;

  typedef enum logic {
    Tcdm   = 1'b0,
    Periph = 1'b1
  } tdemux_target_e;

  localparam int unsigned DmxAddrWidth   = 32;
  localparam int unsigned DmxDataWidth   = 32;
  localparam int unsigned DmxCoreIdWidth = 4;

  typedef struct packed {
    logic [DmxCoreIdWidth-1:0] core_id;
  } dmx_user_t;

  typedef struct packed {
    logic [DmxAddrWidth-1:0]   addr;
    logic                      write;
    logic [DmxDataWidth-1:0]   data;
    logic [DmxDataWidth/8-1:0] strb;
    dmx_user_t                 user;
  } dmx_req_chan_t;

  typedef struct packed {
    logic [DmxDataWidth-1:0] data;
    logic                    error;
  } dmx_rsp_chan_t;

  typedef struct packed {
    dmx_req_chan_t q;
    logic          q_valid;
    logic          p_ready;
  } dmx_req_t;

  typedef struct packed {
    dmx_rsp_chan_t p;
    logic          p_valid;
    logic          q_ready;
  } dmx_rsp_t;

endpackage

// File: rtl/spatz_demux_tracker.sv
// Per-port outstanding counter and sticky target select.
// allow depends only on registered state and the decoded target.
module spatz_demux_tracker
  import spatz_cluster_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  tdemux_target_e i_tgt,
  input  logic           i_q_hs,
  input  logic           i_p_hs,
  output logic           o_allow,
  output tdemux_target_e o_sel,
  output logic           o_idle
);

  typedef logic [$clog2(MaxOutstanding+1)-1:0] cnt_t;

  localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

  cnt_t           r_cnt;
  tdemux_target_e r_sel;

  assign o_idle  = (r_cnt == '0);
  assign o_sel   = r_sel;
  assign o_allow = (r_cnt < CntMax) &&
                   (o_idle || (r_sel == i_tgt));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_sel <= Tcdm;
    end else begin
      if (i_q_hs) begin
        r_sel <= i_tgt;
      end
      unique case ({i_q_hs, i_p_hs})
        2'b10:   r_cnt <= r_cnt + cnt_t'(1);
        2'b01:   r_cnt <= r_cnt - cnt_t'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    i_p_hs |-> (r_cnt != '0));

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (i_q_hs && !i_p_hs) |-> (r_cnt != CntMax));

endmodule

// File: rtl/spatz_tcdm_demux.sv
// Per-core address demux between TCDM and peripheral paths.
// Responses return in order by stalling target switches until idle.
module spatz_tcdm_demux
  import spatz_cluster_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         dreq_t         = dmx_req_t,
  parameter type         drsp_t         = dmx_rsp_t,
  parameter type         addr_t         = logic [AddrWidth-1:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  dreq_t in_req_i     [NrPorts-1:0],
  output drsp_t in_rsp_o     [NrPorts-1:0],
  output dreq_t tcdm_req_o   [NrPorts-1:0],
  input  drsp_t tcdm_rsp_i   [NrPorts-1:0],
  output dreq_t periph_req_o [NrPorts-1:0],
  input  drsp_t periph_rsp_i [NrPorts-1:0],
  input  addr_t tcdm_start_address_i,
  input  addr_t tcdm_end_address_i
);

  for (genvar i = 0; i < NrPorts; i++) begin : g_port
    tdemux_target_e w_tgt;
    tdemux_target_e w_sel;
    logic           w_allow;
    logic           w_idle;
    logic           w_q_hs;
    logic           w_p_hs;
    dreq_t          w_tcdm_req;
    dreq_t          w_periph_req;
    drsp_t          w_in_rsp;

    // An empty or inverted window never matches, so all goes to Periph.
    assign w_tgt =
      ((in_req_i[i].q.addr >= tcdm_start_address_i) &&
       (in_req_i[i].q.addr <  tcdm_end_address_i)) ? Tcdm : Periph;

    always_comb begin
      w_tcdm_req   = in_req_i[i];
      w_periph_req = in_req_i[i];
      w_tcdm_req.q_valid   = in_req_i[i].q_valid && w_allow &&
                             (w_tgt == Tcdm);
      w_periph_req.q_valid = in_req_i[i].q_valid && w_allow &&
                             (w_tgt == Periph);
      w_tcdm_req.p_ready   = in_req_i[i].p_ready && (w_sel == Tcdm);
      w_periph_req.p_ready = in_req_i[i].p_ready && (w_sel == Periph);
      w_in_rsp = tcdm_rsp_i[i];
      unique case (w_sel)
        Tcdm:   w_in_rsp = tcdm_rsp_i[i];
        Periph: w_in_rsp = periph_rsp_i[i];
      endcase
      w_in_rsp.q_ready = w_allow &&
        ((w_tgt == Tcdm) ? tcdm_rsp_i[i].q_ready
                         : periph_rsp_i[i].q_ready);
    end

    assign w_q_hs = in_req_i[i].q_valid && w_in_rsp.q_ready;
    assign w_p_hs = w_in_rsp.p_valid && in_req_i[i].p_ready;

    assign tcdm_req_o[i]   = w_tcdm_req;
    assign periph_req_o[i] = w_periph_req;
    assign in_rsp_o[i]     = w_in_rsp;

    spatz_demux_tracker #(
      .MaxOutstanding(MaxOutstanding)
    ) u_trk (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_tgt  (w_tgt),
      .i_q_hs (w_q_hs),
      .i_p_hs (w_p_hs),
      .o_allow(w_allow),
      .o_sel  (w_sel),
      .o_idle (w_idle)
    );

    a_stray_p: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      w_idle |-> !((w_sel == Tcdm) ? periph_rsp_i[i].p_valid
                                   : tcdm_rsp_i[i].p_valid));

    a_q_stable: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (in_req_i[i].q_valid && !w_in_rsp.q_ready)
        |=> $stable(in_req_i[i].q));
  end

endmodule
